// File: rtl/mult3_ctrl_pkg.sv
// Shared definitions for the 3-bit shift-and-add multiplier: state encodings, widths, step limit.
// Optional operation counter is enabled by defining MULT3_OPCOUNT_EN.
package mult3_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          OP_W      = 3;
  localparam int          PROD_W    = 6;
  localparam logic [1:0]  STEP_LAST = 2'd2;

endpackage

// File: rtl/sum3b.sv
// 3-bit ripple adder with carry in/out; the one adder the multiplier time-shares.
module sum3b (
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic       Ci,
  output logic [2:0] S,
  output logic       Co
);

  assign {Co, S} = {1'b0, A} + {1'b0, B} + {3'b000, Ci};

endmodule

// File: rtl/mult3_ctrl.sv
// Sequential 3x3 unsigned multiplier: one partial-product step per cycle through a shared sum3b.
// Define MULT3_OPCOUNT_EN to add the 8-bit op_count output.
module mult3_ctrl
  import mult3_ctrl_pkg::*;
#(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
`ifdef MULT3_OPCOUNT_EN
  output logic [7:0]     op_count,
`endif
  output logic [2*W-1:0] p
);

  state_t         state, state_nxt;
  logic [W-1:0]   mcand, q, acc_hi;
  logic [1:0]     step;
  logic [2*W-1:0] p_q;

  logic [W-1:0]   add_s;
  logic           add_co;
  logic           carry;
  logic [W-1:0]   acc_sel;

  sum3b u_add (
    .A  (acc_hi),
    .B  (mcand),
    .Ci (1'b0),
    .S  (add_s),
    .Co (add_co)
  );

  // Skip the add when the multiplier bit is 0; carry is then 0.
  assign {carry, acc_sel} = q[0] ? {add_co, add_s} : {1'b0, acc_hi};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (step == STEP_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      q      <= '0;
      acc_hi <= '0;
      step   <= '0;
      p_q    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= a;
          q      <= b;
          acc_hi <= '0;
          step   <= '0;
        end
        CALC: begin
          // {carry,acc_hi,q} shifted right by one after the conditional add
          {acc_hi, q} <= {carry, acc_sel, q[W-1:1]};
          step        <= step + 2'd1;
          if (step == STEP_LAST) p_q <= {carry, acc_sel, q[W-1:1]};
        end
        default: ;
      endcase
    end
  end

`ifdef MULT3_OPCOUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                         op_count <= '0;
    else if (state == CALC && step == STEP_LAST)     op_count <= op_count + 8'd1;
  end
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign p    = p_q;

endmodule
